// File: rtl/uart_imem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_imem_responder_pkg
//  Description : Request flags and FSM state encoding for the UART imem responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_imem_responder_pkg;

    // Request flags shared with the fetch initiator on the CPU side of the link.
    localparam logic [7:0] c_FLAG_FETCH = 8'h03;
    localparam logic [7:0] c_FLAG_LOAD  = 8'h04;

    typedef logic [3:0] state_t;

    localparam state_t c_IDLE     = 4'd0;
    localparam state_t c_GET_ADDR = 4'd1;
    localparam state_t c_READ     = 4'd2;
    localparam state_t c_SEND_HI  = 4'd3;
    localparam state_t c_SEND_LO  = 4'd4;
    localparam state_t c_LD_ADDR  = 4'd5;
    localparam state_t c_LD_HI    = 4'd6;
    localparam state_t c_LD_LO    = 4'd7;
    localparam state_t c_WRITE    = 4'd8;

endpackage
`default_nettype wire

// File: rtl/uart_imem_responder_imem_sp.sv
`default_nettype none
// ============================================================================
//  Module      : imem_sp
//  Description : Single-port synchronous RAM with registered read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_sp #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read-first: a read coinciding with a write returns the old word.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/uart_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : uart_imem_responder
//  Description : UART-side responder serving instruction fetches and program loads.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_imem_responder
    import uart_imem_responder_pkg::*;
#(
    parameter int         ADDR_W     = 8,
    parameter int         TIMEOUT    = 100000,
    parameter logic [7:0] FLAG_FETCH = c_FLAG_FETCH,
    parameter logic [7:0] FLAG_LOAD  = c_FLAG_LOAD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_do,
    input  logic [7:0]  rx_data,
    input  logic        tx_done,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic        proto_err,
    output logic [15:0] fetch_cnt
);

    localparam int                c_TMO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_hi;
    logic [7:0]          r_lo;
    logic [15:0]         r_reply;
    logic [c_TMO_W-1:0]  r_tmo;

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [15:0]         w_mem_rdata;

    // The address byte goes straight to the RAM so READ sees valid data one cycle later.
    always_comb begin
        w_mem_we   = (r_state == c_WRITE) && !reset;
        w_mem_addr = (r_state == c_GET_ADDR) ? rx_data[ADDR_W-1:0] : r_addr;
    end

    imem_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (16)
    ) u_imem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata ({r_hi, r_lo}),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_addr    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_reply   <= '0;
            r_tmo     <= '0;
            tx_start  <= 1'b1;
            tx_data   <= '0;
            busy      <= 1'b0;
            proto_err <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            proto_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tmo <= '0;
                    if (rx_do) begin
                        if (rx_data == FLAG_FETCH) begin
                            r_state <= c_GET_ADDR;
                            busy    <= 1'b1;
                        end else if (rx_data == FLAG_LOAD) begin
                            r_state <= c_LD_ADDR;
                            busy    <= 1'b1;
                        end else begin
                            proto_err <= 1'b1;
                        end
                    end
                end
                c_GET_ADDR, c_LD_ADDR, c_LD_HI, c_LD_LO: begin
                    if (rx_do) begin
                        r_tmo <= '0;
                        case (r_state)
                            c_GET_ADDR: begin
                                r_addr  <= rx_data[ADDR_W-1:0];
                                r_state <= c_READ;
                            end
                            c_LD_ADDR: begin
                                r_addr  <= rx_data[ADDR_W-1:0];
                                r_state <= c_LD_HI;
                            end
                            c_LD_HI: begin
                                r_hi    <= rx_data;
                                r_state <= c_LD_LO;
                            end
                            default: begin
                                r_lo    <= rx_data;
                                r_state <= c_WRITE;
                            end
                        endcase
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_tmo     <= '0;
                        proto_err <= 1'b1;
                        busy      <= 1'b0;
                        r_state   <= c_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_READ: begin
                    r_reply  <= w_mem_rdata;
                    tx_data  <= w_mem_rdata[15:8];
                    tx_start <= 1'b0;
                    r_state  <= c_SEND_HI;
                end
                c_SEND_HI: begin
                    tx_data <= r_reply[15:8];
                    if (tx_done) begin
                        tx_data <= r_reply[7:0];
                        r_state <= c_SEND_LO;
                    end
                end
                c_SEND_LO: begin
                    if (tx_done) begin
                        tx_start  <= 1'b1;
                        busy      <= 1'b0;
                        fetch_cnt <= fetch_cnt + 16'd1;
                        r_state   <= c_IDLE;
                    end
                end
                c_WRITE: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    tx_start <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_imem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_imem_responder
//  Description : Self-checking bench for uart_imem_responder with a TX byte scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_imem_responder;

    localparam int TMO = 50;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_do = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        busy;
    logic        proto_err;
    logic [15:0] fetch_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] exp_cnt = 16'h0000;

    typedef struct {
        logic [7:0]  addr;
        logic [15:0] word;
    } vec_t;

    vec_t vecs[7];

    uart_imem_responder #(
        .ADDR_W  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_do     (rx_do),
        .rx_data   (rx_data),
        .tx_done   (tx_done),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .busy      (busy),
        .proto_err (proto_err),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART transmitter model: each requested byte takes 4 cycles, then tx_done pulses.
    initial begin
        int tx_cnt;
        logic [7:0] e;
        tx_cnt = 0;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!reset && tx_start == 1'b0) begin
                if (tx_cnt == 3) begin
                    if (exp_q.size() == 0) begin
                        check("tx_unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 32'(tx_data), 32'(e));
                    end
                    tx_done = 1'b1;
                    tx_cnt  = 0;
                end else begin
                    tx_cnt++;
                end
            end else begin
                tx_cnt = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_do   = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_do   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] word);
        send_byte(8'h04);
        send_byte(addr);
        send_byte(word[15:8]);
        send_byte(word[7:0]);
        @(negedge clk);
        check("load_done", 32'(busy), 32'd0);
    endtask

    task automatic fetch(input logic [7:0] addr, input logic [15:0] word);
        exp_q.push_back(word[15:8]);
        exp_q.push_back(word[7:0]);
        send_byte(8'h03);
        send_byte(addr);
        wait_idle("fetch");
        exp_cnt = exp_cnt + 16'd1;
        check("fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
    endtask

    initial begin
        int  n;
        int  gaps;
        bit  found;

        vecs[0] = '{8'h00, 16'h0001};
        vecs[1] = '{8'hFF, 16'hFFFF};
        vecs[2] = '{8'h20, 16'h1234};
        vecs[3] = '{8'h7F, 16'h8000};
        vecs[4] = '{8'h80, 16'h00FF};
        vecs[5] = '{8'h55, 16'hA55A};
        vecs[6] = '{8'h01, 16'h0000};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx_start", 32'(tx_start), 32'd1);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_proto_err", 32'(proto_err), 32'd0);
        check("rst_fetch_cnt", 32'(fetch_cnt), 32'd0);
        reset = 1'b0;

        // Load then fetch with latency and continuous tx_start checks
        load(8'h12, 16'hABCD);
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        send_byte(8'h03);
        send_byte(8'h12);
        check("lat_not_yet", 32'(tx_start), 32'd1);
        @(negedge clk);
        check("lat_tx_start", 32'(tx_start), 32'd0);
        check("lat_hi_data", 32'(tx_data), 32'hAB);
        gaps = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (tx_start) gaps++;
        end
        check("tx_start_gap", 32'(gaps), 32'd0);
        check("first_tx_start_high", 32'(tx_start), 32'd1);
        check("first_drained", 32'(exp_q.size()), 32'd0);
        exp_cnt = 16'd1;
        check("first_fetch_cnt", 32'(fetch_cnt), 32'd1);

        // Table of loads, then fetches in reverse order
        for (int i = 0; i < 7; i++) load(vecs[i].addr, vecs[i].word);
        for (int i = 6; i >= 0; i--) fetch(vecs[i].addr, vecs[i].word);

        // Unknown flag
        send_byte(8'h07);
        check("bad_flag_err", 32'(proto_err), 32'd1);
        check("bad_flag_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("bad_flag_pulse", 32'(proto_err), 32'd0);
        fetch(8'h00, 16'h0001);

        // Timeout aborts a partial load
        send_byte(8'h04);
        send_byte(8'h20);
        send_byte(8'hFF);
        n = 0;
        for (int i = 1; i <= TMO + 10; i++) begin
            @(negedge clk);
            if (proto_err) begin
                n = i;
                break;
            end
        end
        check("tmo_cycles", 32'(n), 32'(TMO));
        check("tmo_busy", 32'(busy), 32'd0);
        fetch(8'h20, 16'h1234);

        // Stray RX byte during SEND_HI
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        send_byte(8'h03);
        send_byte(8'h55);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!tx_start) begin
                found = 1'b1;
                break;
            end
        end
        check("stray_reach", 32'(found), 32'd1);
        rx_do   = 1'b1;
        rx_data = 8'h03;
        @(negedge clk);
        rx_do   = 1'b0;
        wait_idle("stray");
        exp_cnt = exp_cnt + 16'd1;
        check("stray_fetch_cnt", 32'(fetch_cnt), 32'(exp_cnt));
        repeat (20) @(negedge clk);
        check("stray_no_reply", 32'(tx_start), 32'd1);
        check("stray_no_busy", 32'(busy), 32'd0);

        // Reset during SEND_LO
        exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD);
        send_byte(8'h03);
        send_byte(8'h12);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx_start && tx_data == 8'hCD) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_mid_reach", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        exp_cnt = 16'd0;
        check("rst_mid_tx_start", 32'(tx_start), 32'd1);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_fetch_cnt", 32'(fetch_cnt), 32'd0);
        fetch(8'h12, 16'hABCD);

        // fetch_cnt wrap
        @(negedge clk);
        force dut.fetch_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.fetch_cnt;
        exp_cnt = 16'hFFFF;
        fetch(8'hFF, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_imem_responder.md
Name: uart_imem_responder

Overview:
- Target-side responder for the UART instruction-fetch protocol, sitting at the far end of the link from the CPU's fetch unit.
- It owns a 16-bit-wide instruction memory. On a fetch request (flag 0x03, then an address byte) it returns the instruction high byte first, then the low byte.
- It also accepts a program-load request (flag 0x04, address, high byte, low byte) that writes one word.
- It connects to a standard UART RX/TX pair.

Parameters:
- ADDR_W, 8, address width; memory depth is 2**ADDR_W words of 16 bits.
- TIMEOUT, 100000, number of idle clk cycles allowed between RX bytes of one request before it is aborted.
- FLAG_FETCH, 8'h03, request flag for an instruction fetch.
- FLAG_LOAD, 8'h04, request flag for a program-load write.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_do  in  1  one-cycle pulse: rx_data holds a valid received byte.
- rx_data  in  8  byte received from the UART.
- tx_done  in  1  one-cycle pulse: the UART finished sending the current byte.
- tx_start  out  1  active-low; held low while a byte is requested, until tx_done.
- tx_data  out  8  byte to transmit; stable while tx_start is low.
- busy  out  1  high in every state except IDLE.
- proto_err  out  1  one-cycle pulse on a timeout abort or an unknown flag.
- fetch_cnt  out  16  number of completed fetch replies; wraps at 0xFFFF -> 0.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, tx_start = 1, tx_data = 0, busy = 0, proto_err = 0, fetch_cnt = 0, timeout counter = 0.
  - Memory contents are NOT cleared.
- All outputs are registered.
- Dispatch on IDLE:
  - rx_do with rx_data == FLAG_FETCH -> GET_ADDR.
  - rx_do with rx_data == FLAG_LOAD -> LD_ADDR.
  - rx_do with any other byte -> proto_err pulse, stay in IDLE.
- Fetch sequence:
  - GET_ADDR: on rx_do, latch addr = rx_data[ADDR_W-1:0] -> READ.
  - READ: one cycle; register mem[addr] into the reply register (synchronous memory read) -> SEND_HI.
  - SEND_HI: tx_start = 0, tx_data = reply[15:8]; on tx_done -> SEND_LO.
  - SEND_LO: tx_start = 0, tx_data = reply[7:0]; on tx_done -> IDLE and fetch_cnt += 1.
  - tx_start stays low continuously from SEND_HI through SEND_LO. It goes back to 1 in the cycle after the final tx_done.
- Load sequence:
  - LD_ADDR: on rx_do, latch addr.
  - LD_HI: on rx_do, latch the high byte.
  - LD_LO: on rx_do, latch the low byte -> WRITE.
  - WRITE: one cycle; mem[addr] <= {hi, lo} -> IDLE. No reply byte is sent.
- Address bytes when ADDR_W < 8: the upper bits of the address byte are ignored.
- Latency: the first reply byte is requested 2 clk cycles after the address-byte rx_do (GET_ADDR -> READ -> SEND_HI).
- Timeout:
  - In GET_ADDR, LD_ADDR, LD_HI and LD_LO, a counter increments each cycle without rx_do and resets on rx_do.
  - When it reaches TIMEOUT-1: proto_err pulse, state -> IDLE, partial load discarded (no write).
  - No timeout applies in the SEND_* states; they wait indefinitely for tx_done.
- Simultaneous or unexpected events:
  - rx_do during READ, SEND_*, or WRITE is ignored. The byte is dropped and no error is raised.
  - tx_done outside the SEND_* states is ignored.
- Read after write: a fetch of an address loaded by the immediately preceding request returns the new word.
- Reset mid-operation: the transfer is aborted at once, tx_start = 1 next cycle, and any pending write is discarded.

Decomposition:
- Shared package holds:
  - FLAG_FETCH / FLAG_LOAD constants, shared with the fetch initiator.
  - The state encoding localparams: IDLE, GET_ADDR, READ, SEND_HI, SEND_LO, LD_ADDR, LD_HI, LD_LO, WRITE.
- Sub-module imem_sp: a single-port synchronous 2**ADDR_W x 16 RAM with registered read, so it can later be swapped for a hard macro.
- The FSM, timeout counter and fetch_cnt stay in the top module.

Test Plan:
- Load then fetch:
  - Stimulus: RX 04,12,AB,CD, then RX 03,12.
  - Response: TX bytes AB then CD; tx_start low from 2 cycles after the address rx_do until the tx_done of CD; fetch_cnt = 1.
- Unknown flag:
  - Stimulus: RX 07 in IDLE.
  - Response: one proto_err pulse; busy stays 0; the following 03,00 fetch still works.
- Timeout:
  - Stimulus: RX 04,20,FF, then silence for TIMEOUT cycles (TIMEOUT = 50 in the bench).
  - Response: proto_err pulse; IDLE; a later fetch of 0x20 returns the prior contents (load not written).
- Stray RX during reply:
  - Stimulus: rx_do with byte 03 while in SEND_HI.
  - Response: ignored; reply completes normally; no second reply is sent.
- Reset mid-reply:
  - Stimulus: assert reset during SEND_LO.
  - Response: next cycle tx_start = 1, busy = 0, fetch_cnt = 0; memory word unchanged on re-fetch.
- Counter wrap:
  - Stimulus: preload fetch_cnt via force to FFFF, then complete one fetch.
  - Response: fetch_cnt = 0000.
